// File: rtl/cpi_pkg.sv
// rtl/cpi_pkg.sv - shared types and constants for the CPI frame packer
package cpi_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2,
    FLUSH      = 2'd3
  } cpi_pack_state_e;

  localparam int PIX_PER_WORD_8  = 4;
  localparam int PIX_PER_WORD_16 = 2;

  // Window fields are held at 16 bits so the struct is independent of CNT_WIDTH.
  typedef struct packed {
    logic [15:0] row_start;
    logic [15:0] row_end;
    logic [15:0] col_start;
    logic [15:0] col_end;
    logic        bpp16;
  } cpi_win_cfg_t;

  function automatic logic [1:0] cpi_last_lane(input logic bpp16);
    return bpp16 ? 2'(PIX_PER_WORD_16 - 1) : 2'(PIX_PER_WORD_8 - 1);
  endfunction

endpackage

// File: rtl/cpi_word_fifo.sv
// rtl/cpi_word_fifo.sv - 32-bit word FIFO; a push on full is accepted only alongside a pop
module cpi_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Head is forced to zero when empty so the output is clean after reset.
  assign rd_data = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/udma_cpi_frame_packer.sv
// rtl/udma_cpi_frame_packer.sv - CPI crop/pack datapath feeding the uDMA RX channel
// Optional row/column decimation enabled by defining CPI_DECIMATION_EN.
module udma_cpi_frame_packer
  import cpi_pkg::*;
#(
  parameter int PIX_WIDTH = 16,
  parameter int CNT_WIDTH = 12,
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_bpp16_i,
  input  logic [CNT_WIDTH-1:0] cfg_row_start_i,
  input  logic [CNT_WIDTH-1:0] cfg_row_end_i,
  input  logic [CNT_WIDTH-1:0] cfg_col_start_i,
  input  logic [CNT_WIDTH-1:0] cfg_col_end_i,
  input  logic                 cfg_clr_i,
`ifdef CPI_DECIMATION_EN
  input  logic [3:0]           cfg_decim_i,
`endif
  input  logic                 cam_valid_i,
  input  logic [PIX_WIDTH-1:0] cam_data_i,
  input  logic                 cam_hsync_i,
  input  logic                 cam_vsync_i,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 overflow_o
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_WAIT    = WAIT_FRAME;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;
  localparam logic [1:0] ST_FLUSH   = FLUSH;

  logic [1:0]           state, state_nxt;
  logic                 hsync_q, vsync_q;
  logic                 vsync_rise, hsync_fall;
  logic [CNT_WIDTH-1:0] row_cnt, col_cnt;
  logic [15:0]          row16, col16, pix16;
  cpi_win_cfg_t         win;
  logic                 in_row, in_col, keep, take, word_done;
  logic [1:0]           lane;
  logic [31:0]          acc, acc_nxt;
  logic                 flush_push, push, pop, fifo_full, fifo_empty;
  logic [31:0]          push_data;

  assign vsync_rise = cam_vsync_i && !vsync_q;
  assign hsync_fall = !cam_hsync_i && hsync_q;
  assign row16      = 16'(row_cnt);
  assign col16      = 16'(col_cnt);
  assign pix16      = 16'(cam_data_i);
  assign in_row     = (row16 >= win.row_start) && (row16 <= win.row_end);
  assign in_col     = (col16 >= win.col_start) && (col16 <= win.col_end);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      hsync_q <= cam_hsync_i;
      vsync_q <= cam_vsync_i;
      if (vsync_rise) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (hsync_fall) begin
        col_cnt <= '0;
        if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
      end else if (cam_valid_i && cam_hsync_i && col_cnt != '1) begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

`ifdef CPI_DECIMATION_EN
  logic [3:0] decim_q, row_ph, col_ph;

  // Phases only advance inside the window, so they restart at the window edges.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      row_ph <= '0;
      col_ph <= '0;
    end else begin
      if (vsync_rise) row_ph <= '0;
      else if (hsync_fall && in_row) row_ph <= (row_ph == decim_q) ? 4'd0 : row_ph + 4'd1;
      if (vsync_rise || hsync_fall) col_ph <= '0;
      else if (cam_valid_i && cam_hsync_i && in_col)
        col_ph <= (col_ph == decim_q) ? 4'd0 : col_ph + 4'd1;
    end
  end

  assign keep = (row_ph == 4'd0) && (col_ph == 4'd0);
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cfg_en_i) state_nxt = ST_WAIT;
      ST_WAIT:    if (!cfg_en_i) state_nxt = ST_IDLE;
                  else if (vsync_rise) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (!cfg_en_i) state_nxt = ST_IDLE;
                  else if (vsync_rise || (hsync_fall && row16 == win.row_end)) state_nxt = ST_FLUSH;
      default:    state_nxt = cfg_en_i ? ST_WAIT : ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
      win   <= '0;
`ifdef CPI_DECIMATION_EN
      decim_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && cfg_en_i && vsync_rise) begin
        win <= '{row_start: 16'(cfg_row_start_i), row_end: 16'(cfg_row_end_i),
                 col_start: 16'(cfg_col_start_i), col_end: 16'(cfg_col_end_i),
                 bpp16: cfg_bpp16_i};
`ifdef CPI_DECIMATION_EN
        decim_q <= cfg_decim_i;
`endif
      end
    end
  end

  assign take = (state == ST_CAPTURE) && cfg_en_i && !vsync_rise && cam_valid_i &&
                cam_hsync_i && in_row && in_col && keep;
  assign word_done = (lane == cpi_last_lane(win.bpp16));

  always_comb begin
    acc_nxt = acc;
    if (win.bpp16) begin
      if (lane[0]) acc_nxt[31:16] = pix16;
      else         acc_nxt[15:0]  = pix16;
    end else begin
      case (lane)
        2'd0:    acc_nxt[7:0]   = pix16[7:0];
        2'd1:    acc_nxt[15:8]  = pix16[7:0];
        2'd2:    acc_nxt[23:16] = pix16[7:0];
        default: acc_nxt[31:24] = pix16[7:0];
      endcase
    end
  end

  // Outside CAPTURE the accumulator is cleared, which also zero-pads partial words.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lane <= '0;
      acc  <= '0;
    end else if (state != ST_CAPTURE) begin
      lane <= '0;
      acc  <= '0;
    end else if (take) begin
      lane <= word_done ? 2'd0 : lane + 2'd1;
      acc  <= word_done ? 32'h0 : acc_nxt;
    end
  end

  assign flush_push = (state == ST_FLUSH) && (lane != 2'd0);
  assign push       = (take && word_done) || flush_push;
  assign push_data  = flush_push ? acc : acc_nxt;
  assign pop        = valid_o && ready_i;
  assign valid_o    = !fifo_empty;

  cpi_word_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                          overflow_o <= 1'b0;
    else if (push && fifo_full && !pop)   overflow_o <= 1'b1;
    else if (cfg_clr_i)                   overflow_o <= 1'b0;
  end

  assign busy_o       = (state != ST_IDLE);
  assign frame_done_o = (state == ST_FLUSH);

endmodule

// File: tb/tb_udma_cpi_frame_packer.sv
// tb/tb_udma_cpi_frame_packer.sv - directed and randomized checks against a pixel-list packing model
module tb_udma_cpi_frame_packer;

  logic        clk = 1'b0;
  logic        rstn_i, cfg_en_i, cfg_bpp16_i, cfg_clr_i;
  logic [11:0] cfg_row_start_i, cfg_row_end_i, cfg_col_start_i, cfg_col_end_i;
  logic [3:0]  cfg_decim;
  logic        cam_valid_i, cam_hsync_i, cam_vsync_i, ready_i;
  logic [15:0] cam_data_i;
  logic [31:0] data_o;
  logic        valid_o, busy_o, frame_done_o, overflow_o;

  int          checks = 0;
  int          failures = 0;
  int          fd_cnt = 0;
  int          gap = 0;
  bit          rand_rdy = 0;
  int          m_rs, m_re, m_cs, m_ce, m_b16, decim;
  logic [31:0] got[$];
  logic [31:0] expw[$];
  logic [15:0] pix_mem [16][16];

  always #5 clk = ~clk;

  udma_cpi_frame_packer #(.PIX_WIDTH(16), .CNT_WIDTH(12), .BUF_DEPTH(4)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_bpp16_i     (cfg_bpp16_i),
    .cfg_row_start_i (cfg_row_start_i),
    .cfg_row_end_i   (cfg_row_end_i),
    .cfg_col_start_i (cfg_col_start_i),
    .cfg_col_end_i   (cfg_col_end_i),
    .cfg_clr_i       (cfg_clr_i),
`ifdef CPI_DECIMATION_EN
    .cfg_decim_i     (cfg_decim),
`endif
    .cam_valid_i     (cam_valid_i),
    .cam_data_i      (cam_data_i),
    .cam_hsync_i     (cam_hsync_i),
    .cam_vsync_i     (cam_vsync_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
    .overflow_o      (overflow_o)
  );

  always @(negedge clk) begin
    if (rstn_i && valid_o && ready_i) got.push_back(data_o);
    if (frame_done_o) fd_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int rs, input int re, input int cs, input int ce, input int b16);
    m_rs = rs; m_re = re; m_cs = cs; m_ce = ce; m_b16 = b16;
    cfg_row_start_i = 12'(rs); cfg_row_end_i = 12'(re);
    cfg_col_start_i = 12'(cs); cfg_col_end_i = 12'(ce);
    cfg_bpp16_i = 1'(b16);
    cfg_decim = 4'(decim);
  endtask

  // Captured pixels in raster order, packed little-endian, last partial word zero-padded.
  task automatic model_frame(input int rows, input int cols);
    logic [31:0] w;
    int ln, ppw, sh;
    ppw = m_b16 ? 2 : 4;
    sh  = m_b16 ? 16 : 8;
    w = 0; ln = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        if (r >= m_rs && r <= m_re && c >= m_cs && c <= m_ce &&
            ((r - m_rs) % (decim + 1)) == 0 && ((c - m_cs) % (decim + 1)) == 0) begin
          w = w | ((m_b16 ? 32'(pix_mem[r][c]) : 32'(pix_mem[r][c][7:0])) << (ln * sh));
          ln++;
          if (ln == ppw) begin
            expw.push_back(w);
            w = 0; ln = 0;
          end
        end
    if (ln != 0) expw.push_back(w);
  endtask

  task automatic vsync_pulse();
    cam_vsync_i = 0; cyc(); cyc();
    cam_vsync_i = 1; cyc(); cyc();
    cam_vsync_i = 0; cyc();
  endtask

  task automatic send_row(input int r, input int c0, input int c1);
    for (int c = c0; c < c1; c++) begin
      cam_data_i = pix_mem[r][c];
      cam_valid_i = 1; cyc();
      cam_valid_i = 0;
      repeat (gap) cyc();
    end
  endtask

  task automatic send_frame(input int rows, input int cols);
    vsync_pulse();
    for (int r = 0; r < rows; r++) begin
      cam_hsync_i = 1; cyc();
      send_row(r, 0, cols);
      cam_hsync_i = 0; cyc(); cyc();
    end
  endtask

  task automatic drain(input string tag, input int n);
    int t = 0;
    while ((got.size() < n || valid_o) && t < 600) begin
      cyc();
      t++;
    end
    check({tag, "_drain_timeout"}, 32'(t < 600), 32'd1);
  endtask

  task automatic run_frame(input string tag, input int rows, input int cols);
    int fd0;
    expw.delete(); got.delete();
    fd0 = fd_cnt;
    model_frame(rows, cols);
    send_frame(rows, cols);
    drain(tag, expw.size());
    check({tag, "_word_count"}, got.size(), expw.size());
    for (int i = 0; i < expw.size() && i < got.size(); i++)
      check({tag, "_word"}, got[i], expw[i]);
    check({tag, "_frame_done"}, fd_cnt - fd0, 1);
  endtask

  initial begin
    rstn_i = 0; cfg_en_i = 0; cfg_clr_i = 0; cam_valid_i = 0; cam_hsync_i = 0;
    cam_vsync_i = 0; cam_data_i = 0; ready_i = 1; decim = 0;
    set_cfg(0, 0, 0, 0, 0);
    cyc(); cyc();
    check("reset_data", data_o, 32'h0);
    check("reset_flags", {28'h0, valid_o, busy_o, frame_done_o, overflow_o}, 32'h0);
    rstn_i = 1; cyc();

    // 8x4 frame, rows 1-2, bpp8; row 1 carries 0x00..0x07
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) pix_mem[r][c] = 16'((r * 8 + c - 8) & 8'hFF);
    set_cfg(1, 2, 0, 7, 0);
    cfg_en_i = 1; cyc(); cyc();
    gap = 0;
    run_frame("bpp8_basic", 4, 8);
    if (got.size() >= 2) begin
      check("bpp8_first_word", got[0], 32'h03020100);
      check("bpp8_second_word", got[1], 32'h07060504);
    end

    // bpp16 partial word padded on FLUSH
    pix_mem[0][0] = 16'hAAAA; pix_mem[0][1] = 16'hBBBB;
    pix_mem[0][2] = 16'hCCCC; pix_mem[0][3] = 16'hDDDD;
    set_cfg(0, 0, 1, 3, 1);
    run_frame("bpp16_pad", 1, 4);
    if (got.size() == 2) begin
      check("bpp16_word0", got[0], 32'hCCCCBBBB);
      check("bpp16_word1", got[1], 32'h0000DDDD);
    end

    // Overflow: 24 pixels into a stalled 4-deep FIFO
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++) pix_mem[r][c] = 16'($urandom);
    set_cfg(0, 2, 0, 7, 0);
    expw.delete(); got.delete();
    model_frame(3, 8);
    ready_i = 0;
    send_frame(3, 8);
    cyc(); cyc();
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_valid_held", 32'(valid_o), 32'd1);
    cfg_clr_i = 1; cyc(); cfg_clr_i = 0;
    check("ovf_cleared", 32'(overflow_o), 32'd0);
    ready_i = 1;
    drain("ovf", 4);
    check("ovf_drained_count", got.size(), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("ovf_drained_word", got[i], expw[i]);

    // Enable dropped mid-capture after two pixels
    set_cfg(0, 3, 0, 7, 0);
    got.delete();
    begin
      int fd0;
      fd0 = fd_cnt;
      vsync_pulse();
      cam_hsync_i = 1; cyc();
      send_row(0, 0, 2);
      cfg_en_i = 0; cyc(); cyc();
      check("en_drop_busy", 32'(busy_o), 32'd0);
      cam_hsync_i = 0; cyc(); cyc(); cyc();
      check("en_drop_no_word", got.size(), 32'd0);
      check("en_drop_no_done", fd_cnt - fd0, 0);
    end

    // Reset asserted mid-frame
    cfg_en_i = 1; ready_i = 0; cyc(); cyc();
    vsync_pulse();
    cam_hsync_i = 1; cyc();
    send_row(0, 0, 6);
    check("rst_mid_word_pending", 32'(valid_o), 32'd1);
    rstn_i = 0; #1;
    check("rst_mid_data", data_o, 32'h0);
    check("rst_mid_flags", {28'h0, valid_o, busy_o, frame_done_o, overflow_o}, 32'h0);
    cyc(); cyc();
    rstn_i = 1; ready_i = 1; got.delete();
    send_row(0, 6, 8);
    cam_hsync_i = 0; cyc(); cyc();
    cam_hsync_i = 1; cyc();
    send_row(1, 0, 8);
    cam_hsync_i = 0; cyc(); cyc();
    check("rst_after_no_capture", got.size(), 32'd0);
    check("rst_after_waiting", 32'(busy_o), 32'd1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) pix_mem[r][c] = 16'($urandom);
    run_frame("rst_next_frame", 4, 8);

`ifdef CPI_DECIMATION_EN
    decim = 1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pix_mem[r][c] = 16'($urandom);
    set_cfg(0, 3, 0, 3, 0);
    run_frame("decim_n1", 4, 4);
    check("decim_one_word", got.size(), 32'd1);
    decim = 0;
`endif

    // Randomized frames, windows (including empty ones) and back-pressure
    gap = 3;
    rand_rdy = 1;
    for (int f = 0; f < 8; f++) begin
      int rows, cols;
      rows = $urandom_range(2, 6);
      cols = $urandom_range(2, 10);
`ifdef CPI_DECIMATION_EN
      decim = $urandom_range(0, 2);
`endif
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) pix_mem[r][c] = 16'($urandom);
      set_cfg($urandom_range(0, rows - 1), $urandom_range(0, rows - 1),
              $urandom_range(0, cols - 1), $urandom_range(0, cols - 1), $urandom_range(0, 1));
      run_frame("rand_frame", rows, cols);
    end
    rand_rdy = 0; ready_i = 1;
    check("rand_no_overflow", 32'(overflow_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udma_cpi_frame_packer.md
Name: udma_cpi_frame_packer

Overview:
Parametrised next-generation CPI capture datapath, running entirely in the peripheral clock domain, downstream of the pad-to-clock synchroniser. Tracks row/column position per frame, crops to a programmable window, optionally decimates, and packs 8- or 16-bit pixels into 32-bit words. Words are buffered in a small FIFO and presented to the uDMA RX channel with valid/ready. Raises frame-done and sticky overflow flags.

Parameters:
PIX_WIDTH, 16, max pixel bus width; 8-bit mode uses bits [7:0]
CNT_WIDTH, 12, row/column counter width (max 4096x4096)
BUF_DEPTH, 4, output word FIFO depth (power of 2, >=2)

Ports:
clk_i  in  1  peripheral clock
rstn_i  in  1  async active-low reset
cfg_en_i  in  1  capture enable
cfg_bpp16_i  in  1  0: 4x8-bit pixels/word; 1: 2x16-bit pixels/word
cfg_row_start_i  in  CNT_WIDTH  first captured row, inclusive
cfg_row_end_i  in  CNT_WIDTH  last captured row, inclusive
cfg_col_start_i  in  CNT_WIDTH  first captured column, inclusive
cfg_col_end_i  in  CNT_WIDTH  last captured column, inclusive
cfg_clr_i  in  1  clear sticky overflow
cam_valid_i  in  1  pixel strobe, one cycle per pixel
cam_data_i  in  PIX_WIDTH  pixel data
cam_hsync_i  in  1  line active, high during a line
cam_vsync_i  in  1  rising edge marks frame start
data_o  out  32  packed word
valid_o  out  1  word available
ready_i  in  1  uDMA accepts word
busy_o  out  1  FSM not in IDLE
frame_done_o  out  1  one-cycle pulse at end of frame
overflow_o  out  1  sticky: word dropped on full FIFO

Behaviour:
- Reset: all outputs 0; counters 0; FIFO empty; FSM IDLE.
- Edge detect: hsync/vsync registered once internally; edges judged against registered copy.
- Counters: col increments on each cam_valid_i while cam_hsync_i=1; col clears on hsync falling edge. Row increments on hsync falling edge. Both clear on vsync rising edge. No wrap: counters saturate at all-ones.
- In-window pixel: row_start<=row<=row_end and col_start<=col<=col_end (current counter values before increment).
- Packing: little-endian; first pixel in [7:0] (8-bit) or [15:0] (16-bit). Word completes on 4th/2nd in-window pixel and is pushed the same cycle. Lane index resets at vsync rising edge only; packing runs across lines.
- FSM: IDLE -cfg_en_i=1-> WAIT_FRAME -vsync rise-> CAPTURE. CAPTURE -(hsync fall with row==row_end) or vsync rise-> FLUSH. FLUSH (1 cycle): push partial word zero-padded if lane!=0; pulse frame_done_o. Then -> WAIT_FRAME if cfg_en_i, else IDLE. A vsync rise that ends CAPTURE is not re-used; the next frame is taken from the following vsync.
- cfg_en_i deasserted in CAPTURE/WAIT_FRAME: -> IDLE next cycle. Partial word dropped, no frame_done. FIFO contents still drain.
- cfg_bpp16_i and window registers are sampled at the vsync rise entering CAPTURE. Changes mid-frame are ignored.
- FIFO: push on word complete; pop on valid_o&&ready_i. valid_o=!empty; data_o=head. Latency: word pushed at cycle N is visible on valid_o at N+1 when FIFO was empty. Push and pop in the same cycle are allowed when full.
- Full: pushed word dropped, overflow_o=1 until cfg_clr_i. If set and clear coincide, set wins.
- row_start>row_end or col_start>col_end: no pixels captured; frame still ends with frame_done_o.

Optional Feature:
CPI_DECIMATION_EN: adds input cfg_decim_i[3:0]=N. Only every (N+1)-th row and column counted from row_start/col_start is captured; N=0 captures every pixel. Decimation counters clear at window start. Without the macro: port absent, every in-window pixel captured.

Decomposition:
- cpi_pkg: cpi_pack_state_e enum {IDLE, WAIT_FRAME, CAPTURE, FLUSH}; constants PIX_PER_WORD_8=4, PIX_PER_WORD_16=2; cfg window struct.
- Sub-module cpi_word_fifo (32-bit, BUF_DEPTH, push/pop/full/empty).

Test Plan:
- 8x4 frame, window rows 1-2 / cols 0-7, bpp8, ready_i=1: expect 4 words, row1 pixels 0x00..0x07 giving data_o 0x03020100, 0x07060504 first; one frame_done_o pulse.
- bpp16, window cols 1-3 on a single captured row, pixels 0xAAAA,0xBBBB,0xCCCC,0xDDDD: expect words 0xCCCCBBBB, then 0x0000DDDD on FLUSH.
- ready_i=0, BUF_DEPTH=4, 24 in-window 8-bit pixels: 4 words held, overflow_o=1. After cfg_clr_i: overflow_o=0; first 4 words drain intact.
- cfg_en_i dropped mid-CAPTURE after 2 pixels: FSM IDLE, no word pushed, no frame_done_o, busy_o=0.
- rstn_i asserted mid-frame: all outputs 0 immediately. After release: no capture until next vsync rise with cfg_en_i=1.
- CPI_DECIMATION_EN, N=1, 4x4 full window: 4 pixels captured (rows 0,2 x cols 0,2), packed into 1 word.
